// File: rtl/pe_pkg.sv
// Shared PE-array definitions: default datapath widths, drain FSM states and
// a constant-evaluable ceil(log2) helper for sizing counters.
package pe_pkg;

  localparam int unsigned PE_PSUM_WIDTH = 32;
  localparam int unsigned PE_DATA_WIDTH = 8;
  localparam int unsigned PE_BIAS_WIDTH = 32;
  localparam int unsigned PE_WIDTH_WGT  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

  // Smallest n with 2**n >= value; used as clog2(count + 1) for counter widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Output-activation stream from the psum drain to the activation buffer.
interface psum_drain_if #(
  parameter int unsigned DATA_WIDTH = pe_pkg::PE_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/psum_requant.sv
// Combinational requantiser: round-half-up, arithmetic right shift, then
// saturate to a signed or unsigned DATA_WIDTH activation.
module psum_requant #(
  parameter int unsigned PSUM_WIDTH  = pe_pkg::PE_PSUM_WIDTH,
  parameter int unsigned DATA_WIDTH  = pe_pkg::PE_DATA_WIDTH,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic [PSUM_WIDTH-1:0]  psum,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   signed_mode,
  output logic [DATA_WIDTH-1:0]  result
);

  // One guard bit so the rounding bias can never overflow.
  localparam int unsigned EXT_W = PSUM_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] ONE  = {{(EXT_W-1){1'b0}}, 1'b1};
  localparam logic signed [EXT_W-1:0] SMAX = {{(EXT_W-DATA_WIDTH+1){1'b0}},
                                              {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SMIN = {{(EXT_W-DATA_WIDTH+1){1'b1}},
                                              {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] UMAX = {{(EXT_W-DATA_WIDTH){1'b0}},
                                              {DATA_WIDTH{1'b1}}};

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] bias;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  assign ext = {psum[PSUM_WIDTH-1], psum};

  // Rounding bias is half an output LSB; a zero shift passes the value through.
  always_comb begin
    bias = '0;
    if (shift != '0) begin
      bias = ONE << (shift - SHIFT_WIDTH'(1));
    end
  end

  // Large shifts fill with the sign bit, leaving 0 or -1 ahead of the clamp.
  assign rounded = ext + bias;
  assign shifted = rounded >>> shift;

  // Saturate into the selected output range.
  always_comb begin
    result = shifted[DATA_WIDTH-1:0];
    if (signed_mode) begin
      if (shifted > SMAX) begin
        result = SMAX[DATA_WIDTH-1:0];
      end else if (shifted < SMIN) begin
        result = SMIN[DATA_WIDTH-1:0];
      end
    end else begin
      if (shifted[EXT_W-1]) begin
        result = '0;
      end else if (shifted > UMAX) begin
        result = UMAX[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Drains a PE column's partial-sum chain from its tail, one psum per cycle,
// requantises each and streams it out over valid/ready.
module psum_drain
  import pe_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH  = PE_PSUM_WIDTH,
  parameter int unsigned DATA_WIDTH  = PE_DATA_WIDTH,
  parameter int unsigned NUM_PE      = 16,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   cfg_signed,
  input  logic [PSUM_WIDTH-1:0]  psum_tail,
  output logic                   chain_shift,
  psum_drain_if.master           out_if,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned      CNT_W    = clog2(NUM_PE + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PE - 1);

  drain_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                   signed_q, signed_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic [DATA_WIDTH-1:0]  requant_data;

  psum_requant #(
    .PSUM_WIDTH  (PSUM_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_requant (
    .psum        (psum_tail),
    .shift       (shift_q),
    .signed_mode (signed_q),
    .result      (requant_data)
  );

  // Shift only when the output register is empty or being emptied this cycle;
  // built from flops and out_ready only, so it settles well before the edge.
  assign chain_shift = (state_q == DRAIN) && (!valid_q || out_if.out_ready);

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;

  // Next-state: FSM, element counter, latched config and output register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    signed_d = signed_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The done cycle still counts as the tail of the previous job.
        if (start && !done_q) begin
          shift_d  = cfg_shift;
          signed_d = cfg_signed;
          cnt_d    = '0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        // A capture also covers a simultaneous transfer: valid stays high.
        if (chain_shift) begin
          data_d  = requant_data;
          valid_d = 1'b1;
          last_d  = (cnt_q == LAST_IDX);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (valid_q && out_if.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any job immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      signed_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      signed_q <= signed_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: a 4-PE and a 1-PE instance, each fed by a
// small behavioural model of the psum chain tail.
module tb_psum_drain;

  logic        clk;
  logic        reset;
  logic        start4, start1;
  logic [4:0]  cfg_shift4, cfg_shift1;
  logic        cfg_signed4, cfg_signed1;
  logic [31:0] tail4, tail1;
  logic        cs4, cs1;
  logic        busy4, busy1;
  logic        done4, done1;

  int n_checks = 0;
  int n_errors = 0;

  psum_drain_if #(.DATA_WIDTH(8)) if4 ();
  psum_drain_if #(.DATA_WIDTH(8)) if1 ();

  psum_drain #(
    .PSUM_WIDTH  (32),
    .DATA_WIDTH  (8),
    .NUM_PE      (4),
    .SHIFT_WIDTH (5)
  ) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .start       (start4),
    .cfg_shift   (cfg_shift4),
    .cfg_signed  (cfg_signed4),
    .psum_tail   (tail4),
    .chain_shift (cs4),
    .out_if      (if4),
    .busy        (busy4),
    .done        (done4)
  );

  psum_drain #(
    .PSUM_WIDTH  (32),
    .DATA_WIDTH  (8),
    .NUM_PE      (1),
    .SHIFT_WIDTH (5)
  ) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .start       (start1),
    .cfg_shift   (cfg_shift1),
    .cfg_signed  (cfg_signed1),
    .psum_tail   (tail1),
    .chain_shift (cs1),
    .out_if      (if1),
    .busy        (busy1),
    .done        (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain model: the tail presents element (shifts since job load).
  logic [31:0] chain4 [4];
  logic [31:0] chain1;
  int          shifts4 = 0;
  int          shifts1 = 0;
  int          base4   = 0;
  int          base1   = 0;
  int          bad_cs  = 0;
  int          off4;
  logic [1:0]  idx4;

  assign off4  = shifts4 - base4;
  assign idx4  = off4[1:0];
  assign tail4 = (off4 >= 0 && off4 < 4) ? chain4[idx4] : 32'h0;
  assign tail1 = (shifts1 == base1) ? chain1 : 32'h0;

  always @(posedge clk) begin
    if (cs4) shifts4 <= shifts4 + 1;
    if (cs1) shifts1 <= shifts1 + 1;
    if (cs4 && if4.out_valid && !if4.out_ready) bad_cs <= bad_cs + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    chain4[0] = a;
    chain4[1] = b;
    chain4[2] = c;
    chain4[3] = d;
    base4     = shifts4;
  endtask

  // Pulse start for one cycle; returns at the negedge after acceptance.
  task automatic go4(input logic [4:0] s, input logic sg);
    @(negedge clk);
    cfg_shift4  = s;
    cfg_signed4 = sg;
    start4      = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // Full-rate drain of 4 elements, optionally re-pulsing start mid-job.
  task automatic run_full(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input bit poke);
    logic [7:0] e [4];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    e[3] = e3;
    if4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_cs"}, {31'b0, cs4}, 32'd1);
      if (poke && i == 1) begin
        start4     = 1'b1;
        cfg_shift4 = 5'd4;
      end
      @(negedge clk);
      start4 = 1'b0;
      check({tag, "_data"}, {24'b0, if4.out_data}, {24'b0, e[i]});
      check({tag, "_valid"}, {31'b0, if4.out_valid}, 32'd1);
      check({tag, "_last"}, {31'b0, if4.out_last}, (i == 3) ? 32'd1 : 32'd0);
    end
    check({tag, "_flush_cs"}, {31'b0, cs4}, 32'd0);
    check({tag, "_flush_busy"}, {31'b0, busy4}, 32'd1);
    @(negedge clk);
    check({tag, "_done"}, {31'b0, done4}, 32'd1);
    check({tag, "_idle_valid"}, {31'b0, if4.out_valid}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy4}, 32'd0);
  endtask

  initial begin
    bit          pat [6];
    int          xfers;
    bit          got_done;
    bit          was_stall;
    logic [7:0]  held;
    logic [7:0]  bp_exp [4];

    reset         = 1'b1;
    start4        = 1'b0;
    start1        = 1'b0;
    cfg_shift4    = 5'd0;
    cfg_shift1    = 5'd0;
    cfg_signed4   = 1'b0;
    cfg_signed1   = 1'b0;
    chain1        = 32'h0;
    if4.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) chain4[i] = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_valid", {31'b0, if4.out_valid}, 32'd0);
    check("rst_last", {31'b0, if4.out_last}, 32'd0);
    check("rst_data", {24'b0, if4.out_data}, 32'd0);
    check("rst_busy", {31'b0, busy4}, 32'd0);
    check("rst_done", {31'b0, done4}, 32'd0);
    check("rst_cs", {31'b0, cs4}, 32'd0);
    check("rst_valid1", {31'b0, if1.out_valid}, 32'd0);
    reset = 1'b0;

    // Basic drain, shift 0, signed
    load4(32'd5, -32'sd3, 32'd127, -32'sd128);
    go4(5'd0, 1'b1);
    run_full("basic", 8'h05, 8'hFD, 8'h7F, 8'h80, 1'b0);
    check("basic_shifts", shifts4 - base4, 32'd4);
    @(negedge clk);
    check("basic_done_pulse", {31'b0, done4}, 32'd0);

    // Rounding and signed saturation, shift 4
    load4(32'd24, 32'd23, -32'sd24, 32'd4096);
    go4(5'd4, 1'b1);
    run_full("round", 8'h02, 8'h01, 8'hFF, 8'h7F, 1'b0);

    // Unsigned saturation, shift 0
    load4(-32'sd50, 32'd300, 32'd200, -32'sd1);
    go4(5'd0, 1'b0);
    run_full("usat", 8'h00, 8'hFF, 8'hC8, 8'h00, 1'b0);

    // Backpressure with ready pattern 1,0,0,1,0,1 repeating
    pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bp_exp    = '{8'h0A, 8'h14, 8'h1E, 8'h28};
    xfers     = 0;
    got_done  = 1'b0;
    was_stall = 1'b0;
    held      = 8'h00;
    load4(32'd10, 32'd20, 32'd30, 32'd40);
    go4(5'd0, 1'b1);
    for (int k = 0; k < 40 && !got_done; k++) begin
      @(negedge clk);
      if4.out_ready = pat[k % 6];
      #1;
      if (was_stall) begin
        check("bp_hold_valid", {31'b0, if4.out_valid}, 32'd1);
        check("bp_hold_data", {24'b0, if4.out_data}, {24'b0, held});
      end
      if (if4.out_valid && if4.out_ready && xfers < 4) begin
        check("bp_order", {24'b0, if4.out_data}, {24'b0, bp_exp[xfers]});
        xfers++;
      end
      was_stall = if4.out_valid && !if4.out_ready;
      held      = if4.out_data;
      if (done4) got_done = 1'b1;
    end
    check("bp_done", {31'b0, got_done}, 32'd1);
    check("bp_xfers", xfers, 32'd4);
    check("bp_shifts", shifts4 - base4, 32'd4);
    check("bp_no_stall_shift", bad_cs, 32'd0);
    if4.out_ready = 1'b1;

    // Start during DRAIN with a different shift is ignored
    @(negedge clk);
    load4(32'd16, 32'd32, 32'd48, 32'd64);
    go4(5'd0, 1'b1);
    run_full("restart", 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    check("restart_shifts", shifts4 - base4, 32'd4);

    // Start in the done cycle is ignored; the following cycle is accepted
    load4(32'd3, 32'd6, -32'sd3, 32'd255);
    cfg_shift4  = 5'd1;
    cfg_signed4 = 1'b1;
    start4      = 1'b1;
    @(negedge clk);
    check("start_at_done_ignored", {31'b0, busy4}, 32'd0);
    @(negedge clk);
    start4 = 1'b0;
    check("start_after_done_accepted", {31'b0, busy4}, 32'd1);
    run_full("after_done", 8'h02, 8'h03, 8'hFF, 8'h7F, 1'b0);

    // Asynchronous reset after two of four elements
    load4(32'd7, 32'd8, 32'd9, 32'd11);
    go4(5'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", {31'b0, if4.out_valid}, 32'd1);
    check("pre_rst_shifts", shifts4 - base4, 32'd2);
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, if4.out_valid}, 32'd0);
    check("arst_data", {24'b0, if4.out_data}, 32'd0);
    check("arst_busy", {31'b0, busy4}, 32'd0);
    check("arst_cs", {31'b0, cs4}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    load4(32'd1, 32'd2, 32'd3, 32'd4);
    go4(5'd0, 1'b1);
    run_full("post_rst", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    check("post_rst_shifts", shifts4 - base4, 32'd4);

    // NUM_PE = 1: 0x100 >> 8 with rounding gives 1
    chain1 = 32'h0000_0100;
    base1  = shifts1;
    @(negedge clk);
    cfg_shift1  = 5'd8;
    cfg_signed1 = 1'b1;
    start1      = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("pe1_cs", {31'b0, cs1}, 32'd1);
    check("pe1_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    check("pe1_data", {24'b0, if1.out_data}, 32'h01);
    check("pe1_valid", {31'b0, if1.out_valid}, 32'd1);
    check("pe1_last", {31'b0, if1.out_last}, 32'd1);
    check("pe1_flush_cs", {31'b0, cs1}, 32'd0);
    @(negedge clk);
    check("pe1_done", {31'b0, done1}, 32'd1);
    check("pe1_idle_valid", {31'b0, if1.out_valid}, 32'd0);
    check("pe1_shifts", shifts1 - base1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Drain/egress end of the PE partial-sum shift chain.
- After accumulation, it clocks the psums out of the tail PE one per cycle by driving the chain's shift/write enables.
- Each psum is requantised (round, arithmetic shift, saturate) to DATA_WIDTH and streamed to the output-activation buffer over a valid/ready handshake.
- One instance per PE column, at the chain tail.

Parameters:
- PSUM_WIDTH, 32, width of partial sums on the chain.
- DATA_WIDTH, 8, width of output activations.
- NUM_PE, 16, number of PEs (psums) per chain; legal range 1..256.
- SHIFT_WIDTH, 5, width of requantisation shift amount.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse to begin draining; sampled only in IDLE.
- cfg_shift  in  SHIFT_WIDTH  right-shift amount, latched on accepted start.
- cfg_signed  in  1  1 = signed output saturation, 0 = unsigned; latched on accepted start.
- psum_tail  in  PSUM_WIDTH  psum_out of the last PE in the chain.
- chain_shift  out  1  drives PE shift and wea_reg1 of every PE in the chain.
- out_data  out  DATA_WIDTH  requantised activation.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream can accept.
- out_last  out  1  marks element NUM_PE-1; qualified by out_valid.
- busy  out  1  high in DRAIN and FLUSH.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset: state = IDLE; chain_shift = 0, out_valid = 0, out_last = 0, out_data = 0, busy = 0, done = 0; counter and cfg registers = 0.
- Reset mid-operation aborts immediately to IDLE with the same values. Chain contents are not restored.
- States: IDLE, DRAIN, FLUSH.
- IDLE:
  - start = 1 latches cfg_shift and cfg_signed, clears cnt, and goes to DRAIN next cycle.
  - start in any other state is ignored.
- DRAIN:
  - chain_shift = (state==DRAIN) & (~out_valid | out_ready). This is combinational and must be glitch-free relative to clk.
  - On each edge with chain_shift = 1:
    - the output register loads requant(psum_tail);
    - out_valid <= 1;
    - out_last <= (cnt == NUM_PE-1);
    - cnt increments.
  - The chain shifts on the same edge, so the tail presents the next psum in the following cycle.
  - Latency is one cycle from tail sample to out_valid.
  - When the edge captures element NUM_PE-1, go to FLUSH. Exactly NUM_PE shifts are issued per job.
- Handshake:
  - A transfer occurs when out_valid & out_ready.
  - out_valid and out_data hold stable while out_valid & ~out_ready.
  - A simultaneous transfer and new capture keeps out_valid = 1 with the new data, giving back-to-back throughput of 1 per cycle.
- FLUSH:
  - chain_shift = 0.
  - On transfer of the last element: out_valid <= 0, out_last <= 0, done <= 1 for one cycle, state <= IDLE.
- Requantisation, with s = latched shift:
  - Sign-extend psum_tail to PSUM_WIDTH+1 bits.
  - If s > 0, add 2^(s-1) (round half up); no overflow in the extended width.
  - Arithmetic right shift by s. s = 0 passes the value unchanged.
  - Signed mode: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Unsigned mode: clamp to [0, 2^DATA_WIDTH-1]; negative values become 0.
  - Shifts s >= PSUM_WIDTH are legal; the result is 0 or -1 before clamp.
- NUM_PE = 1: the first capture goes directly to FLUSH, with out_last = 1 on the only element.
- out_ready held low indefinitely stalls the chain with no loss or duplication of data.

Decomposition:
- Shared package pe_pkg:
  - default widths PSUM_WIDTH, DATA_WIDTH, BIAS_WIDTH, WIDTH_WGT;
  - drain state enum (IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2);
  - helper function clog2 for the counter width (clog2(NUM_PE+1)).
- One combinational sub-module, psum_requant: inputs psum, shift, signed_mode; output DATA_WIDTH result. It is reused later by the bypass path.
- FSM, counter and output register stay in psum_drain.

Test Plan:
- Basic drain:
  - Stimulus: NUM_PE=4, shift=0, signed; tail sequence 5, -3, 127, -128; out_ready=1.
  - Required: chain_shift high 4 consecutive cycles; out_data 5, 0xFD, 0x7F, 0x80 back-to-back; out_last on the 4th; done one cycle after.
- Rounding and saturation:
  - Stimulus: shift=4, signed; tails 24, 23, -24, 4096.
  - Required: 2, 1, -1 (0xFF), 127.
  - Stimulus: unsigned mode; tails -50, 300 with shift=0.
  - Required: 0, 255.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,0,1… over a 4-element job.
  - Required: data held stable while stalled; chain_shift never high while out_valid & ~out_ready; exactly 4 shifts total; 4 transfers in order.
- Start handling:
  - Stimulus: start pulsed again during DRAIN with a different cfg_shift.
  - Required: ignored; original shift used.
  - Stimulus: start in the cycle done is high.
  - Required: ignored, since state is still FLUSH→IDLE; a start the next cycle is accepted.
- Reset mid-job:
  - Stimulus: assert reset asynchronously after 2 of 4 elements.
  - Required: outputs go to reset values immediately, without waiting for clk; a new start after release drains a fresh 4 elements.
- NUM_PE=1 edge:
  - Stimulus: single tail 0x0000_0100, shift=8.
  - Required: out_data 1 with out_last=1; done after handshake.
